// File: rtl/m_wbuart_pkg.sv
// rtl/m_wbuart_pkg.sv - shared encodings and frame constants for the Wishbone UART
package m_wbuart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = FRAME_BITS - 2;

    localparam int SB_RXVALID  = 0;
    localparam int SB_TXFULL   = 1;
    localparam int SB_TXBUSY   = 2;
    localparam int SB_OVERRUN  = 3;
    localparam int SB_FRAMEERR = 4;

endpackage

// File: rtl/m_wbuart_rx.sv
// rtl/m_wbuart_rx.sv - synchronizer, receive FSM and shift register
module m_wbuart_rx
    import m_wbuart_pkg::*;
#(
    parameter int BAUDDIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       frame_err
);

    localparam logic [15:0] HALF_M1 = 16'(BAUDDIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(BAUDDIV - 1);

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;
    uart_state_t state;
    uart_state_t state_nxt;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tick;

    assign rx_s    = sync[1];
    assign rx_byte = shreg;
    assign tick    = (state == ST_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[0], rx};
            rx_prev <= sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // A falling edge is required to arm, so a low line after a frame error never re-triggers.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rx_prev && !rx_s) state_nxt = ST_START;
            ST_START: if (tick) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (tick && bit_idx == 3'(DATA_BITS - 1)) state_nxt = ST_STOP;
            ST_STOP:  if (tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_done = 1'b0;
        frame_err = 1'b0;
        if (state == ST_STOP && tick) begin
            byte_done = rx_s;
            frame_err = !rx_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            cnt <= (state == ST_IDLE || tick) ? 16'd0 : cnt + 16'd1;
            if (state == ST_START) bit_idx <= '0;
            if (state == ST_DATA && tick) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/m_wbuart.sv
// rtl/m_wbuart.sv - Wishbone UART top: bus registers, transmitter, receive buffer
module m_wbuart
    import m_wbuart_pkg::*;
#(
    parameter int BAUDDIV = 104
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [7:0]  DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    input  logic        usartRX,
    output logic        usartTX
);

    localparam logic [15:0] FULL_M1 = 16'(BAUDDIV - 1);

    uart_state_t tx_state;
    uart_state_t tx_state_nxt;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit_idx;
    logic [7:0]  tx_shreg;
    logic [7:0]  hold;
    logic        txfull;
    logic        tx_tick;
    logic        tx_load;
    logic        tx_accept;
    logic        wr_data;
    logic        rd_data;
    logic        rd_status;

    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        frame_err;
    logic [7:0]  rxbuf;
    logic        rxvalid;
    logic        overrun;
    logic        frameerr;
    logic        ovr_set;
    logic [7:0]  status;

    assign wr_data   = STB_I & WE_I & ~ADR_I;
    assign rd_data   = STB_I & ~WE_I & ~ADR_I;
    assign rd_status = STB_I & ~WE_I & ADR_I;

    assign tx_tick   = (tx_cnt == FULL_M1);
    assign tx_load   = txfull & ((tx_state == ST_IDLE) | ((tx_state == ST_STOP) & tx_tick));
    // A write colliding with the hold-to-shifter transfer finds the register freed that cycle.
    assign ACK_O     = STB_I & ~(wr_data & txfull & ~tx_load);
    assign tx_accept = wr_data & ACK_O;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) tx_state <= ST_IDLE;
        else       tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            ST_IDLE:  if (txfull) tx_state_nxt = ST_START;
            ST_START: if (tx_tick) tx_state_nxt = ST_DATA;
            ST_DATA:  if (tx_tick && tx_bit_idx == 3'(DATA_BITS - 1)) tx_state_nxt = ST_STOP;
            ST_STOP:  if (tx_tick) tx_state_nxt = txfull ? ST_START : ST_IDLE;
            default:  tx_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        usartTX = 1'b1;
        case (tx_state)
            ST_START: usartTX = 1'b0;
            ST_DATA:  usartTX = tx_shreg[tx_bit_idx];
            default:  usartTX = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shreg   <= '0;
            hold       <= '0;
            txfull     <= 1'b0;
        end else begin
            tx_cnt <= (tx_state == ST_IDLE || tx_tick) ? 16'd0 : tx_cnt + 16'd1;
            if (tx_state == ST_START) tx_bit_idx <= '0;
            if (tx_state == ST_DATA && tx_tick) tx_bit_idx <= tx_bit_idx + 3'd1;
            if (tx_load) tx_shreg <= hold;
            if (tx_accept) begin
                hold   <= DAT_I;
                txfull <= 1'b1;
            end else if (tx_load) begin
                txfull <= 1'b0;
            end
        end
    end

    m_wbuart_rx #(.BAUDDIV(BAUDDIV)) u_rx (
        .clk       (CLK_I),
        .rst       (RST_I),
        .rx        (usartRX),
        .rx_byte   (rx_byte),
        .byte_done (byte_done),
        .frame_err (frame_err)
    );

    // A data read in the completion cycle frees the buffer, so the new byte lands without overrun.
    assign ovr_set = byte_done & rxvalid & ~rd_data;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rxbuf    <= '0;
            rxvalid  <= 1'b0;
            overrun  <= 1'b0;
            frameerr <= 1'b0;
        end else begin
            if (byte_done && !ovr_set) begin
                rxbuf   <= rx_byte;
                rxvalid <= 1'b1;
            end else if (rd_data) begin
                rxvalid <= 1'b0;
            end
            overrun  <= ovr_set | (overrun & ~rd_status);
            frameerr <= frame_err | (frameerr & ~rd_status);
        end
    end

    always_comb begin
        status              = '0;
        status[SB_RXVALID]  = rxvalid;
        status[SB_TXFULL]   = txfull;
        status[SB_TXBUSY]   = (tx_state != ST_IDLE);
        status[SB_OVERRUN]  = overrun;
        status[SB_FRAMEERR] = frameerr;
    end

    assign DAT_O = (STB_I & ~WE_I) ? {24'b0, (ADR_I ? status : rxbuf)} : 32'b0;

endmodule

// File: tb/tb_m_wbuart.sv
// tb/tb_m_wbuart.sv - directed self-checking bench for m_wbuart at BAUDDIV=4
module tb_m_wbuart;

    logic        clk = 1'b0;
    logic        RST_I;
    logic        STB_I;
    logic        WE_I;
    logic        ADR_I;
    logic [7:0]  DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;
    logic        usartRX;
    logic        usartTX;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    int          waits;

    m_wbuart #(.BAUDDIV(4)) dut (
        .CLK_I   (clk),
        .RST_I   (RST_I),
        .STB_I   (STB_I),
        .WE_I    (WE_I),
        .ADR_I   (ADR_I),
        .DAT_I   (DAT_I),
        .DAT_O   (DAT_O),
        .ACK_O   (ACK_O),
        .usartRX (usartRX),
        .usartTX (usartTX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic we, input logic adr, input logic [7:0] dat,
                      output logic [31:0] rdata, output int nwait);
        @(negedge clk);
        STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
        #1;
        nwait = 0;
        while (ACK_O !== 1'b1 && nwait < 200) begin
            @(negedge clk);
            #1;
            nwait++;
        end
        rdata = DAT_O;
        @(posedge clk);
        #1;
        STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] b, input logic [31:0] exp_dat);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                chk("tx_level", {31'b0, usartTX}, {31'b0, f[i]});
                chk("tx_dat_o", DAT_O, exp_dat);
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            usartRX = f[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        usartRX = 1'b1;
    endtask

    initial begin
        RST_I = 1'b1; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; DAT_I = '0; usartRX = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'b0, usartTX}, 32'd1);
        chk("rst_ack", {31'b0, ACK_O}, 32'd0);
        chk("rst_dat_o", DAT_O, 32'd0);
        RST_I = 1'b0;

        wb(1'b1, 1'b1, 8'hFF, rd, waits);
        chk("stat_wr_wait", waits, 0);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("stat_after_wr", rd, 32'h00);

        // single frame 0xA5 with status held on the bus
        wb(1'b1, 1'b0, 8'hA5, rd, waits);
        chk("a5_wait", waits, 0);
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = 1'b1;
        @(negedge clk);
        chk("a5_pre_tx", {31'b0, usartTX}, 32'd1);
        chk("a5_pre_stat", DAT_O, 32'h02);
        check_frame(8'hA5, 32'h04);
        @(negedge clk);
        chk("a5_post_tx", {31'b0, usartTX}, 32'd1);
        chk("a5_post_stat", DAT_O, 32'h00);
        STB_I = 1'b0;

        // back-to-back writes
        wb(1'b1, 1'b0, 8'h55, rd, waits);
        chk("b2b_w1_wait", waits, 0);
        wb(1'b1, 1'b0, 8'h0F, rd, waits);
        chk("b2b_w2_wait", waits, 0);
        wb(1'b1, 1'b0, 8'hF0, rd, waits);
        chk("b2b_w3_wait", waits, 39);
        check_frame(8'h0F, 32'h0);
        check_frame(8'hF0, 32'h0);
        @(negedge clk);
        chk("b2b_idle", {31'b0, usartTX}, 32'd1);

        // receive 0x3C
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("rx3c_stat", rd, 32'h01);
        wb(1'b0, 1'b0, 8'h00, rd, waits);
        chk("rx3c_data", rd, 32'h3C);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("rx3c_stat2", rd, 32'h00);

        // overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        wb(1'b0, 1'b0, 8'h00, rd, waits);
        chk("ovr_data", rd, 32'h11);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("ovr_stat", rd, 32'h08);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("ovr_clr", rd, 32'h00);

        // glitch, then framing error, then recovery
        @(negedge clk); usartRX = 1'b0;
        @(negedge clk); usartRX = 1'b1;
        repeat (12) @(negedge clk);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("glitch_stat", rd, 32'h00);
        send_rx(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("ferr_stat", rd, 32'h10);
        wb(1'b0, 1'b1, 8'h00, rd, waits);
        chk("ferr_clr", rd, 32'h00);
        send_rx(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        wb(1'b0, 1'b0, 8'h00, rd, waits);
        chk("ferr_recover", rd, 32'h81);

        // reset in mid-frame at data bit 3
        wb(1'b1, 1'b0, 8'h96, rd, waits);
        repeat (18) @(negedge clk);
        chk("mid_bit3", {31'b0, usartTX}, 32'd0);
        RST_I = 1'b1;
        #1;
        chk("mid_rst_tx", {31'b0, usartTX}, 32'd1);
        STB_I = 1'b1; WE_I = 1'b0; ADR_I = 1'b1;
        #1;
        chk("mid_rst_stat", DAT_O, 32'h00);
        @(negedge clk);
        RST_I = 1'b0; STB_I = 1'b0; ADR_I = 1'b0;
        wb(1'b1, 1'b0, 8'h3C, rd, waits);
        chk("post_rst_wait", waits, 0);
        @(negedge clk);
        chk("post_rst_pre", {31'b0, usartTX}, 32'd1);
        check_frame(8'h3C, 32'h0);
        @(negedge clk);
        chk("post_rst_idle", {31'b0, usartTX}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
